// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-seven-segment table for the seven-segment scan controller.
// Segment bit order is {g,f,e,d,c,b,a}; patterns are active-high.
package seven_seg_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_DEC_BIT     = 1;
    localparam int CTRL_BLINK_LSB   = 8;
    localparam int STATUS_PHASE_BIT = 8;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Avalon-MM slave scanning a multiplexed seven-segment display with hex decode, blink and blank.
// Optional SEVEN_SEG_DP_EN adds a decimal-point output driven from DIGITn bit 7.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25000000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [6:0]            seg_out,
`ifdef SEVEN_SEG_DP_EN
    output logic                  dp_out,
`endif
    output logic [NUM_DIGITS-1:0] dig_sel
);

    localparam int         SCAN_W   = $clog2(SCAN_DIV);
    localparam int         BLINK_W  = $clog2(BLINK_DIV);
    localparam logic       POL      = (SEG_ACTIVE_LOW != 0);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);
`ifdef SEVEN_SEG_DP_EN
    localparam int         DW       = 8;
`else
    localparam int         DW       = 7;
`endif

    logic [NUM_DIGITS-1:0][DW-1:0] digit_q;
    logic                          en_q;
    logic                          dec_q;
    logic [NUM_DIGITS-1:0]         blink_q;
    logic [SCAN_W-1:0]             scan_cnt;
    logic [2:0]                    idx_q;
    logic [BLINK_W-1:0]            blink_cnt;
    logic                          phase_q;

    logic                  wr;
    logic [DW-1:0]         cur_digit;
    logic [NUM_DIGITS-1:0] cur_oh;
    logic                  cur_blink;
    logic [6:0]            hex_seg;
    logic [6:0]            pat;
    logic                  blank;
    logic                  unused_wd;

    assign wr        = chipselect & ~write_n;
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= '0;
            en_q    <= 1'b0;
            dec_q   <= 1'b0;
            blink_q <= '0;
        end else if (wr) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                if (address == 4'(i))
                    digit_q[i] <= writedata[DW-1:0];
            if (address == ADDR_CTRL) begin
                en_q    <= writedata[CTRL_EN_BIT];
                dec_q   <= writedata[CTRL_DEC_BIT];
                blink_q <= writedata[CTRL_BLINK_LSB +: NUM_DIGITS];
            end
        end
    end

    // Scan and blink timebases free-run; EN only gates what reaches the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt  <= '0;
            idx_q     <= '0;
            blink_cnt <= '0;
            phase_q   <= 1'b0;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx_q    <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        cur_oh    = '0;
        cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_digit = digit_q[i];
                cur_oh[i] = 1'b1;
                cur_blink = blink_q[i];
            end
        end
    end

    seven_seg_hex_decode u_hex_decode (
        .nibble (cur_digit[3:0]),
        .seg    (hex_seg)
    );

    assign pat   = dec_q ? hex_seg : cur_digit[6:0];
    assign blank = ~en_q | (cur_blink & phase_q);

    // Outputs are built from the same current index, so segments and digit enable move together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_out <= {7{POL}};
            dig_sel <= {NUM_DIGITS{POL}};
`ifdef SEVEN_SEG_DP_EN
            dp_out  <= POL;
`endif
        end else begin
            seg_out <= (blank ? 7'h00 : pat) ^ {7{POL}};
            dig_sel <= (en_q ? cur_oh : '0) ^ {NUM_DIGITS{POL}};
`ifdef SEVEN_SEG_DP_EN
            dp_out  <= (~blank & cur_digit[7]) ^ POL;
`endif
        end
    end

    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (address == 4'(i))
                readdata[DW-1:0] = digit_q[i];
        if (address == ADDR_CTRL) begin
            readdata[CTRL_EN_BIT]                     = en_q;
            readdata[CTRL_DEC_BIT]                    = dec_q;
            readdata[CTRL_BLINK_LSB +: NUM_DIGITS]    = blink_q;
        end
        if (address == ADDR_STATUS) begin
            readdata[2:0]             = idx_q;
            readdata[STATUS_PHASE_BIT] = phase_q;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: cycle-count model of scan/blink plus directed literal checks.
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 4;
    // Blink period deliberately not a multiple of the scan frame so digit 0 sees both phases.
    localparam int BD = 6;
`ifdef SEVEN_SEG_DP_EN
    localparam logic [7:0] DMASK = 8'hFF;
`else
    localparam logic [7:0] DMASK = 8'h7F;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   address = 4'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'd0;
    logic [31:0]  readdata;
    logic [6:0]   seg_out;
    logic [N-1:0] dig_sel;
`ifdef SEVEN_SEG_DP_EN
    logic         dp_out;
`endif

    seven_seg_scan_ctrl #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (SD),
        .BLINK_DIV      (BD),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_out    (seg_out),
`ifdef SEVEN_SEG_DP_EN
        .dp_out     (dp_out),
`endif
        .dig_sel    (dig_sel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0]   m_dig [N];
    logic         m_en, m_dec;
    logic [N-1:0] m_blink;
    int           m_cyc;
    logic [6:0]   e_seg;
    logic [N-1:0] e_dig;
    logic         e_dp;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [1:0] idx_at(input int c);
        return 2'((c / SD) % N);
    endfunction

    function automatic logic phase_at(input int c);
        return ((c / BD) % 2) == 1;
    endfunction

    function automatic logic blank_at(input int c);
        return !m_en || (m_blink[idx_at(c)] && phase_at(c));
    endfunction

    function automatic logic [6:0] seg_at(input int c);
        logic [7:0] d = m_dig[idx_at(c)];
        if (blank_at(c)) return 7'h7F;
        return m_dec ? ~hex7(d[3:0]) : ~d[6:0];
    endfunction

    function automatic logic [N-1:0] dig_at(input int c);
        if (!m_en) return '1;
        return ~(N'(1) << idx_at(c));
    endfunction

    function automatic logic dp_at(input int c);
        logic [7:0] d = m_dig[idx_at(c)];
        return blank_at(c) ? 1'b1 : ~d[7];
    endfunction

    function automatic logic [31:0] rd_at(input logic [3:0] a, input int c);
        logic [31:0] r = '0;
        if (int'(a) < N) r[7:0] = m_dig[a[1:0]];
        else if (a == 4'd8) begin r[0] = m_en; r[1] = m_dec; r[8 +: N] = m_blink; end
        else if (a == 4'd9) begin r[1:0] = idx_at(c); r[8] = phase_at(c); end
        return r;
    endfunction

    // Outputs after edge c reflect model state after c-1 edges.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc   <= 0;
            for (int i = 0; i < N; i++) m_dig[i] <= 8'h00;
            m_en    <= 1'b0;
            m_dec   <= 1'b0;
            m_blink <= '0;
            e_seg   <= 7'h7F;
            e_dig   <= '1;
            e_dp    <= 1'b1;
        end else begin
            e_seg <= seg_at(m_cyc);
            e_dig <= dig_at(m_cyc);
            e_dp  <= dp_at(m_cyc);
            m_cyc <= m_cyc + 1;
            if (chipselect && !write_n) begin
                if (int'(address) < N) m_dig[address[1:0]] <= writedata[7:0] & DMASK;
                else if (address == 4'd8) begin
                    m_en    <= writedata[0];
                    m_dec   <= writedata[1];
                    m_blink <= writedata[8 +: N];
                end
            end
        end
    end

    always @(negedge clk) begin
        check("seg_out", 32'(seg_out), 32'(e_seg));
        check("dig_sel", 32'(dig_sel), 32'(e_dig));
        check("readdata", readdata, rd_at(address, m_cyc));
`ifdef SEVEN_SEG_DP_EN
        check("dp_out", 32'(dp_out), 32'(e_dp));
`endif
    end

    // ---------------- directed ----------------
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wait_dig(input logic [N-1:0] tgt, input string name);
        int i = 0;
        @(negedge clk);
        while (dig_sel !== tgt && i < 100) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(dig_sel), 32'(tgt));
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        address = a;
        #1 check(name, readdata, exp);
    endtask

    initial begin
        logic sawb, sawl, bad1;
        int i;

        // 1: reset hold
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_dig", 32'(dig_sel), 32'hF);
        address = 4'd8;
        #1 check("rst_ctrl", readdata, 32'h0);
        reset_n = 1'b1;

        // 2: hex decode and scan order
        wr(4'd0, 32'h05);
        wr(4'd1, 32'h0A);
        wr(4'd8, 32'h3);
        wait_dig(4'hE, "t2_dig0");
        check("t2_seg0", 32'(seg_out), 32'h12);
        repeat (4) @(negedge clk);
        check("t2_dig1", 32'(dig_sel), 32'hD);
        check("t2_seg1", 32'(seg_out), 32'h08);
        repeat (8) @(negedge clk);
        check("t2_dig3", 32'(dig_sel), 32'h7);
        check("t2_seg3", 32'(seg_out), 32'h40);
        repeat (4) @(negedge clk);
        check("t2_wrap", 32'(dig_sel), 32'hE);

        // 3: raw mode, readback, unmapped/RO writes
        wr(4'd8, 32'h1);
        wr(4'd2, 32'h49);
        wait_dig(4'hB, "t3_dig2");
        check("t3_seg2", 32'(seg_out), 32'h36);
        rd_chk(4'd2, 32'h49, "t3_rd_dig2");
        rd_chk(4'd5, 32'h0, "t3_rd_unmapped");
        wr(4'd9, 32'hFFFF_FFFF);
        wr(4'd12, 32'hFFFF_FFFF);
        rd_chk(4'd12, 32'h0, "t3_rd_addr12");
        wr(4'd2, 32'hC9);
`ifdef SEVEN_SEG_DP_EN
        rd_chk(4'd2, 32'hC9, "t3_rd_bit7");
`else
        rd_chk(4'd2, 32'h49, "t3_rd_bit7");
`endif

        // 4: blink digit 0
        wr(4'd8, 32'h0103);
        address = 4'd9;
        sawb = 1'b0; sawl = 1'b0; bad1 = 1'b0;
        for (i = 0; i < 96; i++) begin
            @(negedge clk);
            if (dig_sel == 4'hE && seg_out == 7'h7F) sawb = 1'b1;
            if (dig_sel == 4'hE && seg_out == 7'h12) sawl = 1'b1;
            if (dig_sel == 4'hD && seg_out == 7'h7F) bad1 = 1'b1;
        end
        check("t4_blank_seen", 32'(sawb), 32'h1);
        check("t4_lit_seen", 32'(sawl), 32'h1);
        check("t4_dig1_blank", 32'(bad1), 32'h0);

        // 5: write DIGIT0 on the edge where the index wraps 3->0
        wr(4'd8, 32'h3);
        i = 0;
        @(negedge clk);
        while ((m_cyc % (SD * N)) != (SD * N - 1) && i < 64) begin
            @(negedge clk);
            i++;
        end
        address = 4'd0; writedata = 32'h0E; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_dig0", 32'(dig_sel), 32'hE);
        check("t5_seg0_new", 32'(seg_out), 32'h06);

        // 6: asynchronous reset mid-slot 2
        wait_dig(4'hB, "t6_dig2");
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_seg", 32'(seg_out), 32'h7F);
        check("t6_rst_dig", 32'(dig_sel), 32'hF);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        address = 4'd9;
        #1 check("t6_status", readdata, 32'h0);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
